mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) round-robin arbiter onto a single memory port
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_req/i_addr                fetch request and byte address
//   i_ready/i_rdata             fetch one-cycle completion pulse and word
//   d_req/d_we/d_addr/d_wdata/d_be   load/store request and payload
//   d_ready/d_rdata             data one-cycle completion pulse and word
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be   memory access, driven only in BUSY
//   mem_ready/mem_rdata         memory completion and read data
//   stall                       some requester is still waiting
//   err                         timeout pulse, coincident with x_ready
//   grant_d                     current or last owner, 1 = data port
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic              err,
  output logic              grant_d
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state, state_nx;
  logic              last_grant;
  logic              owner_d;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [3:0]        lat_be;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [CW-1:0]     cnt;

  logic grant_now, pick_d, done, timed_out;
  logic busy, resp;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    grant_now = 1'b0;
    done      = 1'b0;
    timed_out = 1'b0;
    // Data wins when it is alone, or when both request and fetch went last.
    pick_d    = d_req & (~i_req | ~last_grant);
    case (state)
      IDLE: begin
        if (i_req | d_req) begin
          grant_now = 1'b1;
          state_nx  = BUSY;
        end
      end
      BUSY: begin
        // A late mem_ready on the final allowed cycle still counts as success.
        if (mem_ready) begin
          done     = 1'b1;
          state_nx = RESP;
        end else if (cnt == TO_MAX) begin
          timed_out = 1'b1;
          state_nx  = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      owner_d    <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cnt        <= '0;
    end else begin
      if (grant_now) begin
        last_grant <= pick_d;
        owner_d    <= pick_d;
        lat_we     <= pick_d & d_we;
        lat_addr   <= pick_d ? d_addr : i_addr;
        lat_wdata  <= pick_d ? d_wdata : 32'h0;
        lat_be     <= pick_d ? d_be : 4'hF;
        err_q      <= 1'b0;
        cnt        <= '0;
      end
      if (busy && !mem_ready && cnt != TO_MAX) cnt <= cnt + CW'(1);
      if (done) begin
        rdata_q <= lat_we ? 32'h0 : mem_rdata;
        err_q   <= 1'b0;
      end
      if (timed_out) begin
        rdata_q <= 32'h0;
        err_q   <= 1'b1;
      end
    end
  end

  assign busy = (state == BUSY);
  assign resp = (state == RESP);

  // Memory port comes only from the latched copy, so requester churn is invisible.
  assign mem_req   = busy;
  assign mem_we    = busy & lat_we;
  assign mem_addr  = busy ? lat_addr : '0;
  assign mem_wdata = busy ? lat_wdata : 32'h0;
  assign mem_be    = busy ? lat_be : 4'h0;

  assign i_ready = resp & ~owner_d;
  assign d_ready = resp & owner_d;
  assign i_rdata = i_ready ? rdata_q : 32'h0;
  assign d_rdata = d_ready ? rdata_q : 32'h0;
  assign err     = resp & err_q;
  assign grant_d = owner_d;
  assign stall   = (i_req & ~i_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        err;
  logic        grant_d;

  mem_arbiter #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall(stall), .err(err), .grant_d(grant_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_d, input logic [31:0] rdata, input logic e);
    exp_t x;
    x.is_d  = is_d;
    x.rdata = rdata;
    x.err   = e;
    sb.push_back(x);
  endtask

  // Response monitor: every ready pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst) begin
      if (i_ready || d_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", {62'b0, i_ready, d_ready}, 64'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ready_port", {62'b0, i_ready, d_ready}, e.is_d ? 64'h1 : 64'h2);
          chk("rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
          chk("other_rdata", e.is_d ? i_rdata : d_rdata, 64'h0);
          chk("err", err, e.err);
        end
      end else begin
        chk("rdata_idle", {i_rdata, d_rdata}, 64'h0);
        chk("err_idle", err, 64'h0);
      end
    end
  end

  initial begin
    rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_be = 0; mem_ready = 0; mem_rdata = 0;
    step(); step();
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_port", {mem_we, mem_be, mem_addr, mem_wdata}, 0);
    chk("rst_ready", {i_ready, d_ready, err, grant_d}, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("idle_mem_req", mem_req, 0);
    chk("idle_stall", stall, 0);

    // Single fetch, minimum latency
    step(); i_req = 1; i_addr = 32'hBFC00000; push(0, 32'h00500093, 0);
    @(negedge clk);
    chk("sf_c0_stall", stall, 1);
    chk("sf_c0_mem_req", mem_req, 0);
    step(); mem_ready = 1; mem_rdata = 32'h00500093;
    @(negedge clk);
    chk("sf_c1_mem_req", mem_req, 1);
    chk("sf_c1_addr", mem_addr, 32'hBFC00000);
    chk("sf_c1_we_be", {mem_we, mem_be}, 5'h0F);
    chk("sf_c1_grant_d", grant_d, 0);
    step(); mem_ready = 0; mem_rdata = 0;
    @(negedge clk);
    chk("sf_c2_mem_req", mem_req, 0);
    chk("sf_c2_addr", mem_addr, 0);
    chk("sf_c2_stall", stall, 0);
    step(); i_req = 0;
    @(negedge clk);
    chk("sf_c3_mem_req", mem_req, 0);

    // Simultaneous requests right after reset: fetch first, then store
    step(); rst = 1;
    step(); rst = 0;
    i_req = 1; i_addr = 32'h100;
    d_req = 1; d_we = 1; d_addr = 32'h10000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    push(0, 32'h11111111, 0);
    push(1, 32'h0, 0);
    step(); mem_ready = 1; mem_rdata = 32'h11111111;
    @(negedge clk);
    chk("sim_f_grant_d", grant_d, 0);
    chk("sim_f_port", {mem_we, mem_be, mem_addr}, {1'b0, 4'hF, 32'h100});
    step(); mem_ready = 0;
    step(); i_req = 0;
    step(); mem_ready = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("sim_s_grant_d", grant_d, 1);
    chk("sim_s_port", {mem_we, mem_be, mem_addr}, {1'b1, 4'b0011, 32'h10000});
    chk("sim_s_wdata", mem_wdata, 32'hDEADBEEF);
    step(); mem_ready = 0;
    step(); d_req = 0; d_we = 0; d_be = 0;

    // Round-robin with both requests held for 6 accesses
    step(); i_req = 1; d_req = 1; i_addr = 32'h200; d_addr = 32'h300;
    for (int k = 0; k < 6; k++) begin
      step(); mem_ready = 1; mem_rdata = 32'hA0000000 + 32'(k);
      push(1'(k % 2), 32'hA0000000 + 32'(k), 0);
      @(negedge clk);
      chk($sformatf("rr_grant_d_%0d", k), grant_d, 64'(k % 2));
      chk($sformatf("rr_addr_%0d", k), mem_addr, (k % 2) ? 32'h300 : 32'h200);
      step(); mem_ready = 0;
      if (k == 5) begin i_req = 0; d_req = 0; end
      step();
    end

    // Timeout on a data load (TIMEOUT=4 -> five BUSY cycles)
    d_req = 1; d_we = 0; d_addr = 32'h2000; push(1, 32'h0, 1);
    for (int b = 0; b < 5; b++) begin
      step(); mem_rdata = 32'h99999999;
      if (b == 1) d_addr = 32'hFFFF0000;
      @(negedge clk);
      chk($sformatf("to_mem_req_%0d", b), mem_req, 1);
      chk($sformatf("to_addr_%0d", b), mem_addr, 32'h2000);
    end
    step();
    @(negedge clk);
    chk("to_resp_mem_req", mem_req, 0);
    step(); d_req = 0; d_addr = 0;
    @(negedge clk);
    chk("to_after_mem_req", mem_req, 0);

    // Timeout boundary: mem_ready arrives exactly when the counter hits TIMEOUT
    i_req = 1; i_addr = 32'h40; push(0, 32'hCAFEF00D, 0);
    for (int b = 0; b < 5; b++) begin
      step(); mem_ready = (b == 4); mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      chk($sformatf("tb_mem_req_%0d", b), mem_req, 1);
    end
    step(); mem_ready = 0;
    @(negedge clk);
    chk("tb_resp_mem_req", mem_req, 0);
    step(); i_req = 0;

    // Reset in the middle of a BUSY store
    d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'h55AA; d_be = 4'hF;
    step(); rst = 1;
    @(negedge clk);
    chk("rm_busy_mem_req", mem_req, 1);
    chk("rm_busy_grant_d", grant_d, 1);
    step(); rst = 0; d_we = 0; i_req = 1; i_addr = 32'h500;
    push(0, 32'h77, 0);
    push(1, 32'h88, 0);
    @(negedge clk);
    chk("rm_after_mem_req", mem_req, 0);
    chk("rm_after_ready", {i_ready, d_ready}, 0);
    chk("rm_after_grant_d", grant_d, 0);
    step(); mem_ready = 1; mem_rdata = 32'h77;
    @(negedge clk);
    chk("rm_first_grant_d", grant_d, 0);
    chk("rm_first_addr", mem_addr, 32'h500);
    step(); mem_ready = 0;
    step(); i_req = 0;
    step(); mem_ready = 1; mem_rdata = 32'h88;
    @(negedge clk);
    chk("rm_second_grant_d", grant_d, 1);
    chk("rm_second_addr", mem_addr, 32'h3000);
    step(); mem_ready = 0;
    step(); d_req = 0;
    step(); step();
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
